// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM encoding,
// stage-control payload and the canned stage-control patterns.
package pipe_ctrl_pkg;

    localparam int unsigned MD_TIMEOUT_DEF = 64;
    localparam int unsigned MD_CNT_W       = 8;
    localparam int unsigned CNT_W          = 32;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctl_t;

    // Freeze front end, push a bubble into EX/MEM, let older work drain.
    localparam pipe_ctl_t CTL_HOLD   = pipe_ctl_t'(8'b00011_001);
    localparam pipe_ctl_t CTL_RUN    = pipe_ctl_t'(8'b11111_000);
    localparam pipe_ctl_t CTL_BRANCH = pipe_ctl_t'(8'b11111_110);
    localparam pipe_ctl_t CTL_STALL  = pipe_ctl_t'(8'b00000_000);

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall-cycle and branch-flush counters; both wrap modulo 2^32.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with mul/div wait and watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             muldiv_req,
    input  logic             md_done,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [MD_CNT_W-1:0]  md_cnt_q, md_cnt_d;
    logic                 done_pending_q, done_pending_d;
    logic                 mem_stall;
    pipe_ctl_t            ctl;

    assign mem_stall = dmem_req & ~dmem_ack;

    // Stage control and next-state; outputs are decoded from state and inputs.
    always_comb begin
        ctl            = CTL_STALL;
        md_start       = 1'b0;
        md_timeout     = 1'b0;
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        done_pending_d = done_pending_q;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        ctl = CTL_STALL;
                    end else if (load_use) begin
                        ctl = CTL_HOLD;
                    end else if (muldiv_req) begin
                        ctl      = CTL_HOLD;
                        md_start = 1'b1;
                        state_d  = MD_WAIT;
                        md_cnt_d = '0;
                    end else if (branch_taken) begin
                        ctl = CTL_BRANCH;
                    end else begin
                        ctl = CTL_RUN;
                    end
                end
                MD_WAIT: begin
                    // Saturate so a long memory stall past the limit still expires.
                    md_cnt_d = (md_cnt_q == '1) ? md_cnt_q : md_cnt_q + MD_CNT_W'(1);
                    if (mem_stall) begin
                        ctl = CTL_STALL;
                        if (md_done) begin
                            done_pending_d = 1'b1;
                        end
                    end else if (md_done || done_pending_q) begin
                        ctl            = CTL_RUN;
                        state_d        = RUN;
                        done_pending_d = 1'b0;
                    end else if (md_cnt_q >= MD_LAST) begin
                        ctl            = CTL_RUN;
                        md_timeout     = 1'b1;
                        state_d        = RUN;
                        done_pending_d = 1'b0;
                    end else begin
                        ctl = CTL_HOLD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            md_cnt_q       <= '0;
            done_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            done_pending_q <= done_pending_d;
        end
    end

    assign pc_en        = ctl.pc_en;
    assign if_id_en     = ctl.if_id_en;
    assign id_ex_en     = ctl.id_ex_en;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign mem_wb_en    = ctl.mem_wb_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (~ctl.pc_en),
        .flush_inc    (ctl.if_id_flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
